// File: rtl/imem_pkg.sv
// Shared definitions for the instruction fetch memory.
// Contents:
//   DEF_*          default values for the instr_fetch_mem parameters
//   CNT_W          width of the miss-access cycle counter
//   fetch_state_t  fetch FSM state encoding
package imem_pkg;

  localparam int unsigned DEF_ADDR_W    = 16;
  localparam int unsigned DEF_INS_BYTES = 8;
  localparam int unsigned DEF_DEPTH     = 1024;
  localparam int unsigned DEF_LATENCY   = 5;

  localparam int unsigned CNT_W = 6;

  typedef enum logic [1:0] {
    IDLE,
    MISS,
    RESP
  } fetch_state_t;

endpackage

// File: rtl/imem_bank.sv
// Read-only byte storage for the instruction fetch memory.
// The content is fixed: byte i holds i[7:0]. It is not affected by reset.
// Ports:
//   word_idx  in   index of an INS_BYTES-aligned word (byte address >> log2(INS_BYTES))
//   rdata     out  combinational little-endian word read; byte k at rdata[8k+7:8k]
module imem_bank
  import imem_pkg::*;
#(
  parameter  int unsigned INS_BYTES = DEF_INS_BYTES,
  parameter  int unsigned DEPTH     = DEF_DEPTH,
  localparam int unsigned OFF_W     = $clog2(INS_BYTES),
  localparam int unsigned IDX_W     = $clog2(DEPTH)
) (
  input  logic [IDX_W-OFF_W-1:0]   word_idx,
  output logic [8*INS_BYTES-1:0]   rdata
);

  logic [7:0] mem [DEPTH];

  // Constant-driven array: synthesises to a ROM holding the byte address.
  for (genvar i = 0; i < DEPTH; i++) begin : g_rom
    assign mem[i] = 8'(i);
  end

  always_comb begin
    rdata = '0;
    for (int unsigned k = 0; k < INS_BYTES; k++) begin
      rdata[8*k +: 8] = mem[{word_idx, OFF_W'(k)}];
    end
  end

endmodule

// File: rtl/instr_fetch_mem.sv
// Instruction fetch memory with a single-line buffer.
// A request that hits the buffered line answers in one cycle; a miss runs a
// LATENCY-cycle access to imem_bank, refills the buffer and then answers.
// Ports:
//   clk        in   clock, all state changes on the rising edge
//   rst_n      in   asynchronous active-low reset
//   req        in   fetch request, held until accepted
//   addr       in   byte address of the requested word
//   flush      in   invalidates the line buffer
//   ready      out  request accepted this cycle (IDLE, out of reset)
//   ins_valid  out  one-cycle pulse qualifying ins
//   ins        out  fetched little-endian word, held between pulses
//   busy       out  miss access in progress
module instr_fetch_mem
  import imem_pkg::*;
#(
  parameter int unsigned ADDR_W    = DEF_ADDR_W,
  parameter int unsigned INS_BYTES = DEF_INS_BYTES,
  parameter int unsigned DEPTH     = DEF_DEPTH,
  parameter int unsigned LATENCY   = DEF_LATENCY
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req,
  input  logic [ADDR_W-1:0]      addr,
  input  logic                   flush,
  output logic                   ready,
  output logic                   ins_valid,
  output logic [8*INS_BYTES-1:0] ins,
  output logic                   busy
);

  localparam int unsigned OFF_W  = $clog2(INS_BYTES);
  localparam int unsigned IDX_W  = $clog2(DEPTH);
  localparam int unsigned TAG_W  = ADDR_W - OFF_W;
  localparam int unsigned WIDX_W = IDX_W - OFF_W;
  localparam logic [CNT_W-1:0] LAT_C = CNT_W'(LATENCY);

  fetch_state_t state, state_nx;
  logic [CNT_W-1:0]        cnt, cnt_nx;
  logic [TAG_W-1:0]        lat_tag, lat_tag_nx;
  logic [TAG_W-1:0]        req_tag;
  logic                    buf_valid;
  logic [TAG_W-1:0]        buf_tag;
  logic [8*INS_BYTES-1:0]  buf_data;
  logic [8*INS_BYTES-1:0]  rdata;
  logic                    hit;
  logic                    hit_take;
  logic                    fill;
  logic                    unused_low_bits;

  // Byte offset within the word is irrelevant to the fetch.
  assign req_tag         = addr[ADDR_W-1:OFF_W];
  assign unused_low_bits = ^addr[OFF_W-1:0];

  assign hit = buf_valid && (buf_tag == req_tag) && !flush;

  // Bits of the tag above the storage size wrap the access modulo DEPTH.
  imem_bank #(
    .INS_BYTES (INS_BYTES),
    .DEPTH     (DEPTH)
  ) u_bank (
    .word_idx (lat_tag[WIDX_W-1:0]),
    .rdata    (rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      lat_tag <= '0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      lat_tag <= lat_tag_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    lat_tag_nx = lat_tag;
    hit_take   = 1'b0;
    fill       = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          if (hit) begin
            state_nx = RESP;
            hit_take = 1'b1;
          end else begin
            state_nx   = MISS;
            cnt_nx     = CNT_W'(1);
            lat_tag_nx = req_tag;
          end
        end
      end
      MISS: begin
        // A changed address restarts the access even on the would-be final
        // cycle, so the abandoned word is never presented.
        if (req && (req_tag != lat_tag)) begin
          cnt_nx     = CNT_W'(1);
          lat_tag_nx = req_tag;
        end else if (cnt == LAT_C) begin
          fill     = 1'b1;
          state_nx = RESP;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + CNT_W'(1);
        end
      end
      RESP: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // A fill landing in the same cycle as flush leaves the buffer valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_valid <= 1'b0;
      buf_tag   <= '0;
      buf_data  <= '0;
      ins       <= '0;
    end else begin
      if (fill) begin
        buf_valid <= 1'b1;
        buf_tag   <= lat_tag;
        buf_data  <= rdata;
        ins       <= rdata;
      end else if (flush) begin
        buf_valid <= 1'b0;
      end
      if (hit_take) begin
        ins <= buf_data;
      end
    end
  end

  assign ready     = rst_n && (state == IDLE);
  assign busy      = (state == MISS);
  assign ins_valid = (state == RESP);

endmodule

// File: tb/tb_instr_fetch_mem.sv
// Randomised scoreboard bench for instr_fetch_mem (LATENCY=5 instance) plus a
// short directed run on a LATENCY=1 instance.
module tb_instr_fetch_mem;

  localparam int unsigned LAT   = 5;
  localparam int unsigned DEPTH = 1024;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;
  logic        req   = 1'b0;
  logic        flush = 1'b0;
  logic [15:0] addr  = '0;
  logic        ready, ins_valid, busy;
  logic [63:0] ins;

  logic        req1   = 1'b0;
  logic        flush1 = 1'b0;
  logic [15:0] addr1  = '0;
  logic        ready1, ins_valid1, busy1;
  logic [63:0] ins1;

  always #5 clk = ~clk;

  instr_fetch_mem #(
    .ADDR_W    (16),
    .INS_BYTES (8),
    .DEPTH     (DEPTH),
    .LATENCY   (LAT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .addr      (addr),
    .flush     (flush),
    .ready     (ready),
    .ins_valid (ins_valid),
    .ins       (ins),
    .busy      (busy)
  );

  instr_fetch_mem #(
    .ADDR_W    (16),
    .INS_BYTES (8),
    .DEPTH     (DEPTH),
    .LATENCY   (1)
  ) dut_l1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req1),
    .addr      (addr1),
    .flush     (flush1),
    .ready     (ready1),
    .ins_valid (ins_valid1),
    .ins       (ins1),
    .busy      (busy1)
  );

  int unsigned checks   = 0;
  int unsigned failures = 0;
  int unsigned edge_cnt = 0;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  typedef struct {
    logic [63:0] data;
    int unsigned at_edge;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  logic [63:0] last_ins = '0;

  // Reference model: one buffered line identified by the full aligned address.
  bit          mdl_valid = 1'b0;
  logic [12:0] mdl_tag   = '0;

  function automatic logic [63:0] exp_word(input logic [15:0] a);
    int unsigned base;
    logic [63:0] w;
    w    = '0;
    base = (32'(a) / 8 * 8) % DEPTH;
    for (int k = 0; k < 8; k++) w[8*k +: 8] = 8'((base + 32'(k)) % 256);
    return w;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    failures++;
    $display("FAIL %s: bound expired at t=%0t", name, $time);
  endtask

  // Monitor: every ins_valid pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst_n) begin
      last_ins = '0;
    end else if (ins_valid) begin
      if (sb.size() == 0) begin
        check("unexpected_ins_valid", {63'b0, ins_valid}, 64'd0);
      end else begin
        mon_e = sb.pop_front();
        check("ins_data", ins, mon_e.data);
        check("ins_timing", 64'(edge_cnt), 64'(mon_e.at_edge));
      end
      last_ins = ins;
    end else begin
      check("ins_hold", ins, last_ins);
    end
  end

  task automatic wait_ready(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) timeout("ready_wait");
  endtask

  task automatic fetch(input logic [15:0] a, input bit fl_accept, input int unsigned mid_flush);
    bit          ok;
    bit          hit;
    int unsigned acc;
    int unsigned bcnt;
    logic [12:0] t;
    wait_ready(ok);
    if (!ok) return;
    req   = 1'b1;
    addr  = a;
    flush = fl_accept;
    acc   = edge_cnt + 1;
    t     = a[15:3];
    hit   = mdl_valid && (mdl_tag == t) && !fl_accept;
    sb.push_back('{exp_word(a), hit ? acc : acc + LAT});
    mdl_valid = 1'b1;
    mdl_tag   = t;
    bcnt      = 0;
    for (int i = 1; i <= int'(LAT) + 10; i++) begin
      @(negedge clk);
      req   = 1'b0;
      flush = !hit && (i == int'(mid_flush));
      if (ins_valid) break;
      if (busy) bcnt++;
    end
    flush = 1'b0;
    check(hit ? "busy_hit" : "busy_miss", 64'(bcnt), hit ? 64'd0 : 64'(LAT));
  endtask

  task automatic flush_pulse();
    bit ok;
    wait_ready(ok);
    if (!ok) return;
    flush = 1'b1;
    @(negedge clk);
    flush     = 1'b0;
    mdl_valid = 1'b0;
  endtask

  task automatic abort_fetch(input logic [15:0] a, input logic [15:0] b, input int unsigned m);
    bit          ok;
    int unsigned rst_edge;
    wait_ready(ok);
    if (!ok) return;
    req   = 1'b1;
    addr  = a;
    flush = 1'b1;
    for (int i = 1; i <= int'(m); i++) begin
      @(negedge clk);
      flush = 1'b0;
    end
    check("busy_before_abort", {63'b0, busy}, 64'd1);
    addr     = b;
    rst_edge = edge_cnt + 1;
    sb.push_back('{exp_word(b), rst_edge + LAT});
    mdl_valid = 1'b1;
    mdl_tag   = b[15:3];
    @(negedge clk);
    req = 1'b0;
  endtask

  task automatic reset_mid_miss(input logic [15:0] a, input int unsigned k);
    bit ok;
    wait_ready(ok);
    if (!ok) return;
    req   = 1'b1;
    addr  = a;
    flush = 1'b1;
    for (int i = 1; i <= int'(k); i++) begin
      @(negedge clk);
      req   = 1'b0;
      flush = 1'b0;
    end
    check("busy_before_reset", {63'b0, busy}, 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_ins", ins, 64'd0);
    check("rst_ins_valid", {63'b0, ins_valid}, 64'd0);
    check("rst_busy", {63'b0, busy}, 64'd0);
    check("rst_ready", {63'b0, ready}, 64'd0);
    mdl_valid = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b1;
    #1 check("ready_after_release", {63'b0, ready}, 64'd1);
  endtask

  task automatic l1_run();
    int unsigned acc;
    int unsigned bcnt;
    bit          seen;
    @(negedge clk);
    check("l1_ready", {63'b0, ready1}, 64'd1);
    req1  = 1'b1;
    addr1 = 16'h0018;
    acc   = edge_cnt + 1;
    bcnt  = 0;
    seen  = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      req1 = 1'b0;
      if (ins_valid1) begin
        seen = 1'b1;
        break;
      end
      if (busy1) bcnt++;
    end
    if (!seen) timeout("l1_miss_valid");
    else begin
      check("l1_busy", 64'(bcnt), 64'd1);
      check("l1_miss_data", ins1, exp_word(16'h0018));
      check("l1_miss_timing", 64'(edge_cnt), 64'(acc + 1));
    end
    @(negedge clk);
    req1  = 1'b1;
    addr1 = 16'h001C;
    acc   = edge_cnt + 1;
    seen  = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      req1 = 1'b0;
      if (ins_valid1) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) timeout("l1_hit_valid");
    else begin
      check("l1_hit_data", ins1, exp_word(16'h0018));
      check("l1_hit_timing", 64'(edge_cnt), 64'(acc));
    end
  endtask

  initial begin
    #4_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          ok;
    logic [15:0] a, b, last_a;
    int unsigned r;

    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("reset_ready", {63'b0, ready}, 64'd0);
    check("reset_busy", {63'b0, busy}, 64'd0);
    check("reset_ins_valid", {63'b0, ins_valid}, 64'd0);
    check("reset_ins", ins, 64'd0);
    #1 rst_n = 1'b1;
    #1 check("release_ready", {63'b0, ready}, 64'd1);

    fetch(16'h0003, 1'b0, 0);
    fetch(16'h0005, 1'b0, 0);
    abort_fetch(16'h0008, 16'h0010, 2);
    fetch(16'h0000, 1'b0, 0);
    flush_pulse();
    fetch(16'h0000, 1'b0, 0);
    fetch(16'h0006, 1'b1, 0);
    fetch(16'h0400, 1'b0, 0);
    fetch(16'h0401, 1'b0, 3);
    fetch(16'h0402, 1'b0, 0);
    reset_mid_miss(16'h0020, 2);
    fetch(16'h0020, 1'b0, 0);

    last_a = 16'h0020;
    for (int n = 0; n < 200; n++) begin
      if ($urandom_range(0, 9) < 3) a = last_a ^ 16'($urandom_range(0, 7));
      else a = 16'($urandom_range(0, 127)) | (($urandom_range(0, 3) == 0) ? 16'h0400 : 16'h0000);
      r = $urandom_range(0, 99);
      if (r < 55) begin
        fetch(a, 1'b0, ($urandom_range(0, 3) == 0) ? $urandom_range(1, LAT) : 0);
      end else if (r < 65) begin
        fetch(a, 1'b1, 0);
      end else if (r < 75) begin
        flush_pulse();
      end else if (r < 92) begin
        b = a ^ (16'h0008 << $urandom_range(0, 3));
        abort_fetch(a, b, $urandom_range(1, LAT - 1));
        a = b;
      end else begin
        reset_mid_miss(a, $urandom_range(1, LAT - 1));
      end
      last_a = a;
    end

    wait_ready(ok);
    repeat (3) @(negedge clk);
    check("scoreboard_drained", 64'(sb.size()), 64'd0);

    l1_run();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
